// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic datapath: default widths, the row-index
// width helper, the C row type and the C readout state encoding.
package systolic_pkg;

  localparam int DEF_BITS_AB = 8;
  localparam int DEF_BITS_C  = 16;
  localparam int DEF_DIM     = 8;

  // Width of a row index for a DIM x DIM array; never narrower than one bit.
  function automatic int rowbits(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  // One full row of C at the default geometry, element c in bits [c*BITS_C +: BITS_C].
  typedef logic signed [DEF_DIM-1:0][DEF_BITS_C-1:0] c_row_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

endpackage

// File: rtl/memc_out_reg.sv
// Valid/ready output register for the C readout stream. Holds one captured row
// with its index and last flag; load captures a new row, clear retires the
// final row once it has been accepted.
module memc_out_reg #(
  parameter int DATA_W = 128,
  parameter int ROW_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ROW_W-1:0]  in_row,
  input  logic              in_last,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_last
);

  // Capture a row on load, drop valid on clear, otherwise hold everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      // NOTE: the data register is reset as well, so a reset mid-stream leaves no partial row visible.
      out_data  <= '0;
      out_row   <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_row   <= in_row;
      out_last  <= in_last;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/memc_reader.sv
// Reads the DIM x DIM C matrix out of the systolic array one row per cycle.
// The row pointer drives Crow directly; the array answers combinationally on
// Cout, and each row is captured into a valid/ready output register tagged
// with its index and a last flag. A one-cycle done pulse follows acceptance
// of the final row.
module memc_reader
  import systolic_pkg::*;
#(
  parameter  int BITS_C  = DEF_BITS_C,
  parameter  int DIM     = DEF_DIM,
  localparam int ROWBITS = rowbits(DIM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [ROWBITS-1:0]         Crow,
  input  logic signed [DIM*BITS_C-1:0] Cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DIM*BITS_C-1:0] out_data,
  output logic [ROWBITS-1:0]         out_row,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam logic [ROWBITS-1:0] LAST_ROW = ROWBITS'(DIM - 1);

  state_e             state_q, state_d;
  logic [ROWBITS-1:0] row_ptr_q, row_ptr_d;
  logic               done_d;
  logic               load;
  logic               clear;
  logic               at_last;

  assign at_last = (row_ptr_q == LAST_ROW);

  // State, row pointer and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_ptr_q <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_ptr_q <= row_ptr_d;
      done      <= done_d;
    end
  end

  // Next-state logic: walk the rows while the output register can take one,
  // then wait for the last row to be accepted before returning to IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first so no branch infers a latch.
    state_d   = state_q;
    row_ptr_d = row_ptr_q;
    load      = 1'b0;
    clear     = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          row_ptr_d = '0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        load = !out_valid || out_ready;
        if (load) begin
          if (at_last) state_d = FLUSH;
          else         row_ptr_d = row_ptr_q + ROWBITS'(1);
        end
      end
      FLUSH: begin
        if (out_valid && out_ready) begin
          clear     = 1'b1;
          row_ptr_d = '0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        row_ptr_d = '0;
      end
    endcase
  end

  // The array is addressed straight from the registered pointer, so Crow has
  // no combinational dependency on out_ready.
  assign Crow = row_ptr_q;
  assign busy = (state_q != IDLE);

  memc_out_reg #(
    .DATA_W (DIM * BITS_C),
    .ROW_W  (ROWBITS)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .clear     (clear),
    .in_data   (Cout),
    .in_row    (row_ptr_q),
    .in_last   (at_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_memc_reader.sv
// Bench for memc_reader: a DIM=8/BITS_C=16 instance and a DIM=4/BITS_C=24
// instance, each fed by a behavioural C matrix answering Crow combinationally.
module tb_memc_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // DIM=8, BITS_C=16 instance
  logic         start8, ready8;
  logic [2:0]   crow8;
  logic [127:0] cout8;
  logic         valid8, last8, busy8, done8;
  logic [127:0] data8;
  logic [2:0]   row8;
  logic [15:0]  mat8 [8][8];

  // DIM=4, BITS_C=24 instance
  logic         start4, ready4;
  logic [1:0]   crow4;
  logic [95:0]  cout4;
  logic         valid4, last4, busy4, done4;
  logic [95:0]  data4;
  logic [1:0]   row4;
  logic [23:0]  mat4 [4][4];

  int checks = 0;
  int errors = 0;

  memc_reader #(.BITS_C(16), .DIM(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .Crow(crow8), .Cout(cout8),
    .out_valid(valid8), .out_ready(ready8), .out_data(data8), .out_row(row8),
    .out_last(last8), .busy(busy8), .done(done8)
  );

  memc_reader #(.BITS_C(24), .DIM(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .Crow(crow4), .Cout(cout4),
    .out_valid(valid4), .out_ready(ready4), .out_data(data4), .out_row(row4),
    .out_last(last4), .busy(busy4), .done(done4)
  );

  // Behavioural array: the addressed row appears on Cout in the same cycle.
  always_comb begin
    cout8 = '0;
    for (int c = 0; c < 8; c++) cout8[c*16 +: 16] = mat8[crow8][c];
  end
  always_comb begin
    cout4 = '0;
    for (int c = 0; c < 4; c++) cout4[c*24 +: 24] = mat4[crow4][c];
  end

  function automatic logic [127:0] row_of8(input int r);
    logic [127:0] v;
    for (int c = 0; c < 8; c++) v[c*16 +: 16] = mat8[r][c];
    return v;
  endfunction

  function automatic logic [95:0] row_of4(input int r);
    logic [95:0] v;
    for (int c = 0; c < 4; c++) v[c*24 +: 24] = mat4[r][c];
    return v;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 8-row instance: rows must be accepted in order 0..7,
  // carry the matrix row they name, stay frozen under backpressure, and the
  // cycle after the row-7 handshake must carry done.
  int   exp_row8 = 0;
  int   hs8 = 0;
  int   done_cnt8 = 0;
  bit   done_exp8 = 0;
  bit   pv8 = 0, phs8 = 0;
  logic [127:0] pd8;
  logic [2:0]   pr8;

  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_row8  = 0;
        done_exp8 = 0;
        pv8       = 0;
        phs8      = 0;
      end else begin
        check("done8", done8, done_exp8);
        if (done8) done_cnt8++;
        if (pv8 && !phs8) begin
          check("hold_valid8", valid8, 1);
          check("hold_data8", data8, pd8);
          check("hold_row8", row8, pr8);
        end
        if (valid8) check("last8", last8, row8 == 3'd7);
        hs = valid8 && ready8;
        if (hs) begin
          check("row8", row8, exp_row8);
          check("data8", data8, row_of8(exp_row8));
          hs8++;
        end
        done_exp8 = hs && (exp_row8 == 7);
        if (hs) exp_row8 = (exp_row8 + 1) % 8;
        pv8  = valid8;
        phs8 = hs;
        pd8  = data8;
        pr8  = row8;
      end
    end
  end

  task automatic start8_pulse();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  // Run the 8-row readout until done, optionally with random backpressure.
  task automatic wait_done8(input string tag, input bit rand_ready);
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      ready8 = rand_ready ? (($urandom % 3) != 0) : 1'b1;
      tick();
      if (done8) begin
        seen = 1;
        break;
      end
    end
    ready8 = 1'b1;
    check(tag, seen, 1);
  endtask

  initial begin
    int h0, d0, n4;
    bit seen4;

    rst_n  = 1'b0;
    start8 = 1'b0;
    ready8 = 1'b1;
    start4 = 1'b0;
    ready4 = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mat8[r][c] = 16'(r * 16 + c);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mat4[r][c] = 24'($urandom);

    // Reset state
    repeat (2) tick();
    check("rst_valid8", valid8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_crow8", crow8, 0);
    check("rst_data8", data8, 0);
    check("rst_row8", row8, 0);
    check("rst_last8", last8, 0);
    check("rst_valid4", valid4, 0);
    check("rst_busy4", busy4, 0);
    #2 rst_n = 1'b1;
    tick();

    // Full readout at one row per cycle
    h0 = hs8;
    start8_pulse();
    check("t1_busy", busy8, 1);
    check("t1_valid0", valid8, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t1_valid", valid8, 1);
      check("t1_row", row8, k);
      check("t1_crow", crow8, (k < 7) ? k + 1 : 7);
    end
    tick();
    check("t1_done", done8, 1);
    check("t1_busy_end", busy8, 0);
    check("t1_valid_end", valid8, 0);
    check("t1_crow_end", crow8, 0);
    check("t1_hs", hs8 - h0, 8);
    tick();
    check("t1_done_once", done8, 0);

    // Backpressure while row 2 is presented
    h0 = hs8;
    start8_pulse();
    repeat (3) tick();
    check("t2_row2", row8, 2);
    ready8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_row", row8, 2);
      check("t2_hold_crow", crow8, 3);
      check("t2_hold_valid", valid8, 1);
    end
    ready8 = 1'b1;
    tick();
    check("t2_row3", row8, 3);
    wait_done8("t2_done_timeout", 0);
    check("t2_hs", hs8 - h0, 8);
    tick();

    // Random matrices with extreme corner values under random backpressure
    for (int run = 0; run < 3; run++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) mat8[r][c] = 16'($urandom);
      mat8[0][0] = 16'h8000;
      mat8[7][7] = 16'h7fff;
      mat8[3][5] = 16'hffff;
      h0 = hs8;
      start8_pulse();
      wait_done8("t3_done_timeout", 1);
      check("t3_hs", hs8 - h0, 8);
      tick();
    end

    // A start during an active readout is ignored
    h0 = hs8;
    d0 = done_cnt8;
    start8_pulse();
    repeat (5) tick();
    check("t4_row4", row8, 4);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("t4_row5", row8, 5);
    wait_done8("t4_done_timeout", 0);
    tick();
    check("t4_hs", hs8 - h0, 8);
    check("t4_done_count", done_cnt8 - d0, 1);

    // Start in the very cycle done is high is accepted
    start8_pulse();
    wait_done8("t5_done_timeout", 0);
    h0 = hs8;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("t5_busy", busy8, 1);
    wait_done8("t5_done2_timeout", 0);
    check("t5_hs", hs8 - h0, 8);
    tick();

    // Asynchronous reset while row 3 is held
    start8_pulse();
    repeat (4) tick();
    check("t6_row3", row8, 3);
    ready8 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", valid8, 0);
    check("t6_busy", busy8, 0);
    check("t6_crow", crow8, 0);
    check("t6_data", data8, 0);
    check("t6_row", row8, 0);
    #3 rst_n = 1'b1;
    ready8 = 1'b1;
    tick();
    start8_pulse();
    tick();
    check("t6_first_row", row8, 0);
    check("t6_first_data", data8, row_of8(0));
    wait_done8("t6_done_timeout", 0);
    tick();

    // DIM=4, BITS_C=24: timing scales to four rows
    mat4[0][0] = 24'h800000;
    mat4[3][3] = 24'h7fffff;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t7_valid", valid4, 1);
      check("t7_row", row4, k);
      check("t7_last", last4, k == 3);
      check("t7_data", data4, row_of4(k));
    end
    tick();
    check("t7_done", done4, 1);
    check("t7_busy", busy4, 0);
    check("t7_valid_end", valid4, 0);
    tick();
    check("t7_done_once", done4, 0);

    // DIM=4 with random backpressure and fresh random data
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mat4[r][c] = 24'($urandom);
    n4 = 0;
    seen4 = 0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ready4 = ($urandom % 2) != 0;
      if (valid4 && ready4) begin
        check("t8_row", row4, n4);
        check("t8_data", data4, row_of4(n4));
        n4++;
      end
      tick();
      if (done4) begin
        seen4 = 1;
        break;
      end
    end
    ready4 = 1'b1;
    check("t8_done_seen", seen4, 1);
    check("t8_hs", n4, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
